// File: rtl/miriscv_lsu_pkg.sv
// Shared definitions for the miriscv load/store unit: access-size encodings,
// FSM state encoding and the latched request record.
package miriscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    STATE_IDLE        = 2'd0,
    STATE_WAIT_GNT    = 2'd1,
    STATE_WAIT_RVALID = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Undefined size codes behave as word accesses, so they need word alignment too.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] offset);
    case (size)
      LDST_B, LDST_BU: return 1'b0;
      LDST_H, LDST_HU: return offset[0];
      default:         return (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// Lane steering for the LSU: byte enables and store-data replication from size
// and byte offset, plus load lane extraction with sign/zero extension.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    byte_lane = mem_rdata_i[{offset_i, 3'b000} +: 8];
    half_lane = offset_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    be_o      = 4'b1111;
    wdata_o   = wdata_i;
    rdata_o   = mem_rdata_i;
    case (size_i)
      LDST_B, LDST_BU: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (size_i == LDST_B) ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      end
      LDST_H, LDST_HU: begin
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (size_i == LDST_H) ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv load/store unit: request/grant/response handshake to data memory with
// optional response timeout. Define MIRISCV_LSU_MISALIGN_EN to trap misaligned accesses.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_bus_err_o,
`ifdef MIRISCV_LSU_MISALIGN_EN
  output logic        lsu_misaligned_o,
`endif
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d, cur_req;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned, req_valid, timeout_hit, abort, load_done;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  // In IDLE the request goes out the same cycle, so steer from the live inputs.
  always_comb begin
`ifdef MIRISCV_LSU_MISALIGN_EN
    misaligned       = (state_q == STATE_IDLE) & lsu_req_i & ~rst_i &
                       is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
    lsu_misaligned_o = misaligned;
`else
    misaligned       = 1'b0;
`endif
    req_valid   = lsu_req_i & ~rst_i & ~misaligned;
    cur_req     = (state_q == STATE_IDLE) ?
                  '{we: lsu_we_i, size: lsu_size_i, addr: lsu_addr_i, wdata: lsu_wdata_i} : req_q;
    timeout_hit = (RESP_TIMEOUT != 0) && (cnt_q >= RESP_TIMEOUT - 1);
    abort       = timeout_hit & ((state_q == STATE_WAIT_GNT) |
                                 ((state_q == STATE_WAIT_RVALID) & ~data_rvalid_i));
    load_done   = (state_q == STATE_WAIT_RVALID) & data_rvalid_i & ~req_q.we;
  end

  miriscv_lsu_align u_align (
    .size_i      (cur_req.size),
    .offset_i    (cur_req.addr[1:0]),
    .wdata_i     (cur_req.wdata),
    .mem_rdata_i (data_rdata_i),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= STATE_IDLE;
    else       state_q <= state_d;
  end

  // Timeout wins over a late grant: data_req_o is already dropped in that cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_IDLE:        if (req_valid) state_d = data_gnt_i ? STATE_WAIT_RVALID : STATE_WAIT_GNT;
      STATE_WAIT_GNT:    if (timeout_hit) state_d = STATE_IDLE;
                         else if (data_gnt_i) state_d = STATE_WAIT_RVALID;
      STATE_WAIT_RVALID: if (data_rvalid_i || timeout_hit) state_d = STATE_IDLE;
      default:           state_d = STATE_IDLE;
    endcase
  end

  always_comb begin
    data_req_o  = 1'b0;
    lsu_stall_o = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        data_req_o  = req_valid;
        lsu_stall_o = req_valid;
      end
      STATE_WAIT_GNT: begin
        data_req_o  = ~timeout_hit;
        lsu_stall_o = ~timeout_hit;
      end
      STATE_WAIT_RVALID: lsu_stall_o = ~data_rvalid_i & ~timeout_hit;
      default: ;
    endcase
    lsu_bus_err_o = abort;
    data_we_o     = data_req_o & cur_req.we;
    data_be_o     = data_req_o ? al_be : 4'b0000;
    data_addr_o   = data_req_o ? {cur_req.addr[31:2], 2'b00} : 32'h0;
    data_wdata_o  = data_req_o ? al_wdata : 32'h0;
    if (load_done)                lsu_rdata_o = al_rdata;
    else if (abort || misaligned) lsu_rdata_o = 32'h0;
    else                          lsu_rdata_o = rdata_q;
  end

  always_comb begin
    req_d = req_q;
    if ((state_q == STATE_IDLE) && req_valid) req_d = cur_req;
    cnt_d = ((state_q == STATE_IDLE) || (state_d == STATE_IDLE)) ? 32'h0 : cnt_q + 32'd1;
    rdata_d = rdata_q;
    if (load_done)                rdata_d = al_rdata;
    else if (abort || misaligned) rdata_d = 32'h0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q   <= '0;
      cnt_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
